// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
//   Multi-digit BCD up/down counter with a time-multiplexed digit scanner that
//   feeds a BCD-to-7-segment decoder one digit at a time.
//
//   Parameters
//     DIGITS   : number of BCD digits (1..8)
//     SCAN_DIV : clk cycles spent on each digit scan slot (>= 1)
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   synchronous reset, active-low
//     en         in   count enable, one step per cycle
//     up         in   1 = increment, 0 = decrement
//     load       in   synchronous load of load_val (wins over en)
//     load_val   in   BCD load value, nibble 0 = least significant digit
//     lamp_test  in   (LAMP_TEST_EN only) active-high lamp test
//     count      out  registered BCD count
//     carry      out  one-cycle pulse on wrap in either direction
//     bcd_out    out  nibble of the scanned digit (decoder Entrada)
//     digit_sel  out  one-hot active-high select of the scanned digit
//     bi_out     out  active-low blanking (decoder BI), leading-zero suppression
//     lt_out     out  active-low lamp test (decoder LT)
//
//   Optional feature macro: LAMP_TEST_EN
//     Defined   : adds lamp_test; while high, lt_out=0, bi_out=1 and every digit
//                 is selected. Counting and scanning carry on underneath.
//     Undefined : no lamp_test port, lt_out is a constant 1.

module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef LAMP_TEST_EN
  input  logic                  lamp_test,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  bi_out,
  output logic                  lt_out
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] count_reg;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_clean;
  logic                carry_reg;
  logic [PW-1:0]       pre_reg;
  logic [IW-1:0]       scan_idx_reg;
  logic [3:0]          bcd_reg;
  logic [DIGITS-1:0]   digit_sel_reg;
  logic                bi_reg;
  logic                lt_reg;

  logic [3:0]          digit_arr [DIGITS];
  // all_nine[i] / all_zero[i]: every digit below i is 9 / 0, i.e. digit i steps.
  logic [DIGITS:0]     all_nine;
  logic [DIGITS:0]     all_zero;
  // lead_zero[i]: digit i and every more-significant digit are 0.
  logic [DIGITS:0]     lead_zero;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] ld;
      assign cur            = count_reg[4*gi +: 4];
      assign ld             = load_val[4*gi +: 4];
      assign digit_arr[gi]  = cur;
      // Non-BCD nibbles load as 0 so the count always stays valid BCD.
      assign load_clean[4*gi +: 4] = (ld > 4'd9) ? 4'd0 : ld;
      assign count_next[4*gi +: 4] =
          up ? (all_nine[gi] ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) : cur)
             : (all_zero[gi] ? ((cur == 4'd0) ? 4'd9 : cur - 4'd1) : cur);
    end
  endgenerate

  always_comb begin
    all_nine      = '0;
    all_zero      = '0;
    lead_zero     = '0;
    all_nine[0]   = 1'b1;
    all_zero[0]   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_nine[i+1] = all_nine[i] & (digit_arr[i] == 4'd9);
      all_zero[i+1] = all_zero[i] & (digit_arr[i] == 4'd0);
    end
    lead_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] & (digit_arr[i] == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      pre_reg       <= '0;
      scan_idx_reg  <= '0;
      bcd_reg       <= 4'd0;
      digit_sel_reg <= DIGITS'(1);
      bi_reg        <= 1'b1;
      lt_reg        <= 1'b1;
    end else begin
      if (load) begin
        count_reg <= load_clean;
        carry_reg <= 1'b0;
      end else if (en) begin
        count_reg <= count_next;
        carry_reg <= up ? all_nine[DIGITS] : all_zero[DIGITS];
      end else begin
        carry_reg <= 1'b0;
      end

      // Free-running prescaler; the scan index moves on its terminal count.
      if (pre_reg == PRE_LAST) begin
        pre_reg      <= '0;
        scan_idx_reg <= (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + IW'(1);
      end else begin
        pre_reg <= pre_reg + PW'(1);
      end

      // Scan outputs follow the current index/count with one cycle of latency.
      bcd_reg <= digit_arr[scan_idx_reg];
`ifdef LAMP_TEST_EN
      if (lamp_test) begin
        digit_sel_reg <= '1;
        bi_reg        <= 1'b1;
        lt_reg        <= 1'b0;
      end else begin
        digit_sel_reg <= DIGITS'(1) << scan_idx_reg;
        bi_reg        <= !((scan_idx_reg != '0) && lead_zero[scan_idx_reg]);
        lt_reg        <= 1'b1;
      end
`else
      digit_sel_reg <= DIGITS'(1) << scan_idx_reg;
      bi_reg        <= !((scan_idx_reg != '0) && lead_zero[scan_idx_reg]);
      lt_reg        <= 1'b1;
`endif
    end
  end

  assign count     = count_reg;
  assign carry     = carry_reg;
  assign bcd_out   = bcd_reg;
  assign digit_sel = digit_sel_reg;
  assign bi_out    = bi_reg;
`ifdef LAMP_TEST_EN
  assign lt_out    = lt_reg;
`else
  assign lt_out    = 1'b1;
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with DIGITS=2, SCAN_DIV=4.
// Inputs change 1 ns after a rising edge, outputs are sampled at that point.

module tb_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       carry;
  logic [3:0] bcd_out;
  logic [1:0] digit_sel;
  logic       bi_out;
  logic       lt_out;
`ifdef LAMP_TEST_EN
  logic       lamp_test;
`endif

  int total = 0;
  int bad   = 0;

  bcd_scan_counter #(.DIGITS(2), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
`ifdef LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .count     (count),
    .carry     (carry),
    .bcd_out   (bcd_out),
    .digit_sel (digit_sel),
    .bi_out    (bi_out),
    .lt_out    (lt_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
`ifdef LAMP_TEST_EN
    lamp_test = 1'b0;
`endif
    repeat (3) tick();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL rst_count: got %h need 00", count); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL rst_carry: got %b need 0", carry); end
    total++; if (digit_sel !== 2'b01) begin bad++; $display("FAIL rst_sel: got %b need 01", digit_sel); end
    total++; if (bcd_out !== 4'd0) begin bad++; $display("FAIL rst_bcd: got %0d need 0", bcd_out); end
    total++; if (bi_out !== 1'b1) begin bad++; $display("FAIL rst_bi: got %b need 1", bi_out); end
    total++; if (lt_out !== 1'b1) begin bad++; $display("FAIL rst_lt: got %b need 1", lt_out); end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin
        total++;
        if (digit_sel !== 2'b01) begin bad++; $display("FAIL scan_start edge%0d: got %b need 01", k, digit_sel); end
      end else begin
        total++;
        if (digit_sel !== 2'b10) begin bad++; $display("FAIL scan_advance edge5: got %b need 10", digit_sel); end
        total++;
        if (bi_out !== 1'b0) begin bad++; $display("FAIL scan_blank edge5: got %b need 0", bi_out); end
      end
    end
    $display("reset: done, total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_count_up();
    load_val = 8'h98; load = 1'b1; tick(); load = 1'b0;
    total++; if (count !== 8'h98) begin bad++; $display("FAIL up_load: got %h need 98", count); end
    en = 1'b1; up = 1'b1; tick();
    total++; if (count !== 8'h99 || carry !== 1'b0) begin bad++; $display("FAIL up_step1: got %h/%b need 99/0", count, carry); end
    tick();
    total++; if (count !== 8'h00 || carry !== 1'b1) begin bad++; $display("FAIL up_wrap: got %h/%b need 00/1", count, carry); end
    en = 1'b0; tick();
    total++; if (count !== 8'h00 || carry !== 1'b0) begin bad++; $display("FAIL up_hold: got %h/%b need 00/0", count, carry); end
    load_val = 8'h19; load = 1'b1; tick(); load = 1'b0; en = 1'b1; tick(); en = 1'b0;
    total++; if (count !== 8'h20 || carry !== 1'b0) begin bad++; $display("FAIL up_ripple: got %h/%b need 20/0", count, carry); end
    load_val = 8'h00; load = 1'b1; tick(); load = 1'b0;
    $display("count_up: done, total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_count_down();
    en = 1'b1; up = 1'b0; tick(); en = 1'b0;
    total++; if (count !== 8'h99 || carry !== 1'b1) begin bad++; $display("FAIL dn_wrap: got %h/%b need 99/1", count, carry); end
    tick();
    total++; if (count !== 8'h99 || carry !== 1'b0) begin bad++; $display("FAIL dn_hold: got %h/%b need 99/0", count, carry); end
    load_val = 8'h10; load = 1'b1; tick(); load = 1'b0; en = 1'b1; tick(); en = 1'b0;
    total++; if (count !== 8'h09 || carry !== 1'b0) begin bad++; $display("FAIL dn_borrow: got %h/%b need 09/0", count, carry); end
    $display("count_down: done, total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_blanking();
    // value, digit0 bcd, digit0 bi, digit1 bcd, digit1 bi
    logic [7:0] vals [4] = '{8'h05, 8'h00, 8'h50, 8'h37};
    logic [3:0] d0b  [4] = '{4'd5, 4'd0, 4'd0, 4'd7};
    logic       d0i  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] d1b  [4] = '{4'd0, 4'd0, 4'd5, 4'd3};
    logic       d1i  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 4; c++) begin
      int seen0 = 0;
      int seen1 = 0;
      load_val = vals[c]; load = 1'b1; tick(); load = 1'b0; tick();
      for (int t = 0; t < 10; t++) begin
        tick();
        if (digit_sel === 2'b01) begin
          seen0++;
          total++;
          if (bcd_out !== d0b[c] || bi_out !== d0i[c]) begin
            bad++; $display("FAIL blank_d0 val=%h: got %0d/%b need %0d/%b", vals[c], bcd_out, bi_out, d0b[c], d0i[c]);
          end
        end else if (digit_sel === 2'b10) begin
          seen1++;
          total++;
          if (bcd_out !== d1b[c] || bi_out !== d1i[c]) begin
            bad++; $display("FAIL blank_d1 val=%h: got %0d/%b need %0d/%b", vals[c], bcd_out, bi_out, d1b[c], d1i[c]);
          end
        end else begin
          total++; bad++;
          $display("FAIL blank_onehot val=%h: got %b need 01 or 10", vals[c], digit_sel);
        end
      end
      total++;
      if (seen0 == 0 || seen1 == 0) begin
        bad++; $display("FAIL blank_coverage val=%h: got seen0=%0d seen1=%0d need both >0", vals[c], seen0, seen1);
      end
`ifndef LAMP_TEST_EN
      total++; if (lt_out !== 1'b1) begin bad++; $display("FAIL lt_idle: got %b need 1", lt_out); end
`endif
      $display("blanking val=%h: seen0=%0d seen1=%0d bad=%0d", vals[c], seen0, seen1, bad);
    end
  endtask

  task automatic test_load_priority();
    load_val = 8'h99; load = 1'b1; tick();
    load_val = 8'hA3; en = 1'b1; up = 1'b1; tick();
    load = 1'b0; en = 1'b0;
    total++; if (count !== 8'h03 || carry !== 1'b0) begin bad++; $display("FAIL ld_prio: got %h/%b need 03/0", count, carry); end
    load_val = 8'h9F; load = 1'b1; tick(); load = 1'b0;
    total++; if (count !== 8'h90) begin bad++; $display("FAIL ld_clean: got %h need 90", count); end
    $display("load_priority: done, total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid();
    load_val = 8'h47; load = 1'b1; tick(); load = 1'b0;
    en = 1'b1; up = 1'b1; tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; en = 1'b0;
    total++; if (count !== 8'h00 || digit_sel !== 2'b01 || carry !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got %h/%b/%b need 00/01/0", count, digit_sel, carry);
    end
    $display("reset_mid: done, total=%0d bad=%0d", total, bad);
  endtask

`ifdef LAMP_TEST_EN
  task automatic test_lamp();
    load_val = 8'h20; load = 1'b1; tick(); load = 1'b0;
    lamp_test = 1'b1; en = 1'b1; up = 1'b1; tick();
    total++; if (lt_out !== 1'b0 || bi_out !== 1'b1 || digit_sel !== 2'b11) begin
      bad++; $display("FAIL lamp_on: got lt=%b bi=%b sel=%b need 0/1/11", lt_out, bi_out, digit_sel);
    end
    total++; if (count !== 8'h21) begin bad++; $display("FAIL lamp_count1: got %h need 21", count); end
    tick();
    total++; if (count !== 8'h22) begin bad++; $display("FAIL lamp_count2: got %h need 22", count); end
    lamp_test = 1'b0; en = 1'b0; tick();
    total++; if (lt_out !== 1'b1 || (digit_sel !== 2'b01 && digit_sel !== 2'b10)) begin
      bad++; $display("FAIL lamp_off: got lt=%b sel=%b need 1/onehot", lt_out, digit_sel);
    end
    $display("lamp: done, total=%0d bad=%0d", total, bad);
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_blanking();
    test_load_priority();
    test_reset_mid();
`ifdef LAMP_TEST_EN
    test_lamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
